// File: rtl/note_lane_scroller.sv
// rtl/note_lane_scroller.sv - one falling-note lane: spawn queue, fall, hit window, miss, flash.
// Optional streak counter built only when NOTE_STREAK_COUNTER_EN is defined.
module note_lane_scroller #(
    parameter int FALL_STEP    = 4,
    parameter int HIT_Y_MIN    = 360,
    parameter int HIT_Y_MAX    = 420,
    parameter int MISS_Y       = 480,
    parameter int FLASH_FRAMES = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       spawn_valid,
    output logic       spawn_ready,
    input  logic       button,
    output logic [9:0] note_y_position,
    output logic       note_active,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic [7:0] streak
);

    typedef enum logic [1:0] {IDLE, FALL, HIT_FLASH, MISS} state_t;

    localparam int FLASH_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_FRAMES - 1);

    state_t             state_q, state_d;
    logic               pending_q, pending_d;
    logic [9:0]         y_q, y_d;
    logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
    logic               hit_pulse_q, hit_pulse_d;
    logic               miss_pulse_q, miss_pulse_d;
    logic               sync1_q, sync2_q, btn_prev_q;

    logic        press;
    logic        in_window;
    logic [10:0] y_next;

    assign press     = sync2_q & ~btn_prev_q;
    assign y_next    = {1'b0, y_q} + 11'(FALL_STEP);
    assign in_window = (y_q >= 10'(HIT_Y_MIN)) && (y_q <= 10'(HIT_Y_MAX));

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        y_d          = y_q;
        flash_cnt_d  = flash_cnt_q;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;

        if (spawn_valid && !pending_q) begin
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    pending_d = 1'b0;
                    y_d       = 10'd0;
                    state_d   = FALL;
                end
            end
            FALL: begin
                // A press is judged against the pre-move y and beats a same-cycle tick.
                if (press && in_window) begin
                    hit_pulse_d = 1'b1;
                    flash_cnt_d = '0;
                    state_d     = HIT_FLASH;
                end else if (frame_tick) begin
                    if (y_next >= 11'(MISS_Y)) begin
                        miss_pulse_d = 1'b1;
                        state_d      = MISS;
                    end else begin
                        y_d = y_next[9:0];
                    end
                end
            end
            HIT_FLASH: begin
                if (frame_tick) begin
                    if (flash_cnt_q == FLASH_LAST) begin
                        flash_cnt_d = '0;
                        state_d     = IDLE;
                    end else begin
                        flash_cnt_d = flash_cnt_q + 1'b1;
                    end
                end
            end
            MISS: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pending_q    <= 1'b0;
            y_q          <= 10'd0;
            flash_cnt_q  <= '0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            btn_prev_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            y_q          <= y_d;
            flash_cnt_q  <= flash_cnt_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            sync1_q      <= button;
            sync2_q      <= sync1_q;
            btn_prev_q   <= sync2_q;
        end
    end

`ifdef NOTE_STREAK_COUNTER_EN
    logic [7:0] streak_q, streak_d;

    always_comb begin
        streak_d = streak_q;
        if (miss_pulse_q) begin
            streak_d = 8'd0;
        end else if (hit_pulse_d && (streak_q != 8'hFF)) begin
            streak_d = streak_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            streak_q <= 8'd0;
        end else begin
            streak_q <= streak_d;
        end
    end

    assign streak = streak_q;
`else
    assign streak = 8'd0;
`endif

    assign spawn_ready     = ~pending_q;
    assign note_y_position = y_q;
    assign note_active     = (state_q == FALL);
    assign hit_pulse       = hit_pulse_q;
    assign miss_pulse      = miss_pulse_q;

endmodule
